// File: rtl/race_ready_source.sv
// Upstream stimulus stage for the race handshake: launches `ready` after an
// LFSR-derived delay, runs a four-phase handshake against start/done and aborts on timeout.
module race_ready_source #(
    parameter int          LFSR_WIDTH  = 8,
    parameter logic [7:0]  SEED        = 8'hA5,
    parameter int          MIN_WAIT    = 2,
    parameter logic [7:0]  WAIT_MASK   = 8'h0F,
    parameter int          TIMEOUT     = 64,
    parameter int          COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   start,
    input  logic                   done,
    output logic                   ready,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] race_count,
    output logic                   timeout_err
);

    localparam int DCNT_MAX = MIN_WAIT + int'(WAIT_MASK);
    localparam int DCNT_W   = (DCNT_MAX < 1) ? 1 : $clog2(DCNT_MAX + 1);
    localparam int TCNT_W   = $clog2(TIMEOUT);
    localparam logic [7:0]        SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ASSERT,
        S_COOLDOWN
    } state_t;

    state_t                 state_reg, state_next;
    logic [DCNT_W-1:0]      cnt_reg, cnt_next;
    logic [TCNT_W-1:0]      tcnt_reg, tcnt_next;
    logic                   ready_reg, ready_next;
    logic                   terr_reg, terr_next;
    logic [COUNT_WIDTH-1:0] count_reg, count_next;
    logic [LFSR_WIDTH-1:0]  lfsr_reg, lfsr_next;
    logic [DCNT_W-1:0]      delay;
    logic                   quiet;

    // Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
    assign lfsr_next[0] = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
    genvar gi;
    generate
        for (gi = 1; gi < LFSR_WIDTH; gi++) begin : g_shift
            assign lfsr_next[gi] = lfsr_reg[gi-1];
        end
    endgenerate

    // Delay uses the LFSR value seen before this edge's shift.
    assign delay = DCNT_W'(MIN_WAIT) + DCNT_W'(lfsr_reg[7:0] & WAIT_MASK);
    assign quiet = !start && !done;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tcnt_next  = tcnt_reg;
        ready_next = ready_reg;
        terr_next  = 1'b0;
        count_next = count_reg;
        case (state_reg)
            S_IDLE: begin
                if (en && quiet) begin
                    cnt_next   = delay;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (quiet) begin
                    ready_next = 1'b1;
                    tcnt_next  = '0;
                    state_next = S_ASSERT;
                end
            end
            S_ASSERT: begin
                // An acknowledge on the limit edge still counts as a completed race.
                if (start) begin
                    ready_next = 1'b0;
                    count_next = count_reg + 1'b1;
                    state_next = S_COOLDOWN;
                end else if (tcnt_reg == TCNT_LAST) begin
                    ready_next = 1'b0;
                    terr_next  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    tcnt_next = tcnt_reg + 1'b1;
                end
            end
            S_COOLDOWN: begin
                if (quiet) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                ready_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            tcnt_reg  <= '0;
            ready_reg <= 1'b0;
            terr_reg  <= 1'b0;
            count_reg <= '0;
            lfsr_reg  <= LFSR_WIDTH'(SEED_EFF);
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            tcnt_reg  <= tcnt_next;
            ready_reg <= ready_next;
            terr_reg  <= terr_next;
            count_reg <= count_next;
            lfsr_reg  <= lfsr_next;
        end
    end

    assign ready       = ready_reg;
    assign busy        = (state_reg != S_IDLE);
    assign race_count  = count_reg;
    assign timeout_err = terr_reg;

endmodule

// File: tb/tb_race_ready_source.sv
// Randomized bench for race_ready_source: launch delays are predicted from a
// reference LFSR sequence; handshake outcomes from the response timing chosen.
module tb_race_ready_source;

    localparam int         MIN_WAIT  = 2;
    localparam logic [7:0] WAIT_MASK = 8'h0F;
    localparam int         TIMEOUT   = 4;
    localparam int         CW        = 2;
    localparam logic [7:0] SEED      = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          start = 1'b0;
    logic          done = 1'b0;
    logic          ready, busy, timeout_err;
    logic [CW-1:0] race_count;

    int errors = 0;
    int checks = 0;

    logic [7:0] lfsr_m    = 8'h00;
    logic [7:0] lfsr_prev = 8'h00;

    race_ready_source #(
        .LFSR_WIDTH (8),
        .SEED       (SEED),
        .MIN_WAIT   (MIN_WAIT),
        .WAIT_MASK  (WAIT_MASK),
        .TIMEOUT    (TIMEOUT),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .start      (start),
        .done       (done),
        .ready      (ready),
        .busy       (busy),
        .race_count (race_count),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Reference pseudo-random sequence; lfsr_prev holds the value before the latest edge.
    always @(posedge clk) begin
        lfsr_prev <= lfsr_m;
        lfsr_m    <= rst ? SEED : lfsr_step(lfsr_m);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; start = 1'b0; done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Enables launching from IDLE; reports edges until busy, edges from launch to ready,
    // and the delay predicted for the launch edge (-1 where a bound expired).
    task automatic do_launch(output int to_busy, output int to_ready, output int d_exp);
        to_busy = -1; to_ready = -1; d_exp = -1;
        en = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (busy === 1'b1) begin
                to_busy = i;
                break;
            end
        end
        if (to_busy < 0) return;
        d_exp = MIN_WAIT + int'(lfsr_prev & WAIT_MASK);
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (ready === 1'b1) begin
                to_ready = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (race_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", race_count); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_terr: got %b expected 0", timeout_err); end
    endtask

    task automatic test_launch();
        int tb, tr, d;
        do_reset();
        do_launch(tb, tr, d);
        checks++; if (tb != 1) begin errors++; $display("FAIL launch_busy_edge: got %0d expected 1", tb); end
        checks++; if (tr != d + 1) begin errors++; $display("FAIL launch_latency: got %0d expected %0d", tr, d + 1); end
        $display("launch: D=%0d ready after %0d edges", d, tr);
    endtask

    task automatic test_handshake();
        int tb, tr, d;
        do_reset();
        do_launch(tb, tr, d);
        start = 1'b1;
        tick();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hs_ready_fall: got %b expected 0", ready); end
        checks++; if (race_count !== 2'd1) begin errors++; $display("FAIL hs_count: got %0d expected 1", race_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_cooldown_busy: got %b expected 1", busy); end
        start = 1'b0; done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (busy !== 1'b1 || ready !== 1'b0) begin
                errors++; $display("FAIL hs_hold_cooldown: busy=%b ready=%b expected busy=1 ready=0", busy, ready);
            end
        end
        done = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_exit_idle: got busy=%b expected 0", busy); end
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hs_relaunch: got busy=%b expected 1", busy); end
        $display("handshake: race_count=%0d", race_count);
    endtask

    task automatic test_timeout();
        int tb, tr, d, hi;
        do_reset();
        do_launch(tb, tr, d);
        en = 1'b0;
        hi = (ready === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ready !== 1'b1) break;
            hi++;
            checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early_terr: got %b expected 0", timeout_err); end
        end
        checks++; if (hi != TIMEOUT) begin errors++; $display("FAIL to_ready_cycles: got %0d expected %0d", hi, TIMEOUT); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_terr_pulse: got %b expected 1", timeout_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: got busy=%b expected 0", busy); end
        checks++; if (race_count !== 2'd0) begin errors++; $display("FAIL to_count: got %0d expected 0", race_count); end
        tick();
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_terr_one_cycle: got %b expected 0", timeout_err); end
        $display("timeout: ready high %0d cycles", hi);
    endtask

    task automatic test_collision();
        int tb, tr, d;
        do_reset();
        do_launch(tb, tr, d);
        en = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL col_ready_before: got %b expected 1", ready); end
        start = 1'b1;
        tick();
        checks++; if (race_count !== 2'd1) begin errors++; $display("FAIL col_count: got %0d expected 1", race_count); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL col_terr: got %b expected 0", timeout_err); end
        checks++; if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL col_cooldown: busy=%b ready=%b expected busy=1 ready=0", busy, ready); end
        start = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL col_exit: got busy=%b expected 0", busy); end
        $display("collision: race_count=%0d", race_count);
    endtask

    task automatic test_gating();
        int d;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            start = 1'($urandom_range(0, 1));
            done  = 1'($urandom_range(0, 1));
            tick();
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gate_en_low: got busy=%b expected 0", busy); end
        end
        start = 1'b0; done = 1'b0; en = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gate_launch: got busy=%b expected 1", busy); end
        d = MIN_WAIT + int'(lfsr_prev & WAIT_MASK);
        en = 1'b0; done = 1'b1;
        for (int i = 0; i < d + 5; i++) begin
            tick();
            checks++;
            if (ready !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL gate_done_hold: ready=%b busy=%b expected ready=0 busy=1", ready, busy);
            end
        end
        done = 1'b0;
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL gate_rise_after_done: got %b expected 1", ready); end
        $display("gating: D=%0d ready rose after done dropped", d);
    endtask

    task automatic test_reset_mid();
        int tb, tr, d;
        do_reset();
        do_launch(tb, tr, d);
        start = 1'b1; tick(); start = 1'b0; tick();
        checks++; if (race_count !== 2'd1) begin errors++; $display("FAIL rm_count_pre: got %0d expected 1", race_count); end
        do_launch(tb, tr, d);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rm_ready_pre: got %b expected 1", ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rm_ready: got %b expected 0", ready); end
        checks++; if (race_count !== 2'd0) begin errors++; $display("FAIL rm_count: got %0d expected 0", race_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", busy); end
        $display("reset mid-assert: ready=%b race_count=%0d", ready, race_count);
    endtask

    task automatic test_wrap();
        int tb, tr, d;
        int exp_count;
        do_reset();
        exp_count = 0;
        for (int i = 0; i < 4; i++) begin
            do_launch(tb, tr, d);
            start = 1'b1; tick();
            exp_count = (exp_count + 1) % (1 << CW);
            checks++; if (int'(race_count) != exp_count) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", race_count, exp_count); end
            start = 1'b0; tick();
            $display("wrap race %0d: race_count=%0d", i, race_count);
        end
        checks++; if (race_count !== 2'd0) begin errors++; $display("FAIL wrap_final: got %0d expected 0", race_count); end
    endtask

    task automatic test_random();
        int tb, tr, d, resp, hold;
        int exp_count;
        do_reset();
        exp_count = 0;
        for (int r = 0; r < 50; r++) begin
            do_launch(tb, tr, d);
            checks++;
            if (tb < 0 || tr != d + 1) begin
                errors++; $display("FAIL rnd_latency: race %0d got %0d expected %0d", r, tr, d + 1);
                break;
            end
            checks++; if (d < 2 || d > 17) begin errors++; $display("FAIL rnd_delay_range: got %0d expected 2..17", d); end
            resp = int'($urandom_range(0, 5));
            if (resp < TIMEOUT) begin
                for (int i = 0; i < resp; i++) tick();
                start = 1'b1;
                tick();
                exp_count = (exp_count + 1) % (1 << CW);
                checks++;
                if (int'(race_count) != exp_count || timeout_err !== 1'b0 || ready !== 1'b0) begin
                    errors++; $display("FAIL rnd_complete: count=%0d terr=%b ready=%b expected count=%0d terr=0 ready=0",
                                       race_count, timeout_err, ready, exp_count);
                end
                start = 1'b0;
                hold = int'($urandom_range(0, 3));
                done = (hold > 0);
                for (int i = 0; i < hold; i++) tick();
                done = 1'b0;
                tick();
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_cooldown_exit: got busy=%b expected 0", busy); end
                $display("race %0d: D=%0d resp=%0d completed count=%0d", r, d, resp, race_count);
            end else begin
                for (int i = 0; i < TIMEOUT; i++) tick();
                checks++;
                if (timeout_err !== 1'b1 || ready !== 1'b0 || busy !== 1'b0 || int'(race_count) != exp_count) begin
                    errors++; $display("FAIL rnd_timeout: terr=%b ready=%b busy=%b count=%0d expected terr=1 ready=0 busy=0 count=%0d",
                                       timeout_err, ready, busy, race_count, exp_count);
                end
                $display("race %0d: D=%0d resp=%0d timed out", r, d, resp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_launch();
        test_handshake();
        test_timeout();
        test_collision();
        test_gating();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/race_ready_source.md
Name: race_ready_source

Overview:
- Upstream stimulus stage for the race handshake: generates the `ready` request consumed by race_official.
- Replaces ad-hoc bench stimulus with synthesizable RTL:
  - LFSR-driven pseudo-random launch delay
  - four-phase handshake against `start`/`done`
  - no-response timeout
  - completed-race counter
- Sits between the free-running clock domain and race_official; observes `done` from race_observer.

Parameters:
- LFSR_WIDTH, 8, width of internal LFSR (only 8 supported; polynomial fixed).
- SEED, 8'hA5, LFSR reset value; SEED==0 is replaced by 8'h01.
- MIN_WAIT, 2, minimum launch delay in cycles.
- WAIT_MASK, 8'h0F, mask ANDed with LFSR to form the random part of the delay.
- TIMEOUT, 64, cycles `ready` may stay high without `start` before abort (>=2).
- COUNT_WIDTH, 8, width of race_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  launch enable; gates only new launches.
- start  in  1  from race_official; acknowledges `ready`.
- done  in  1  from race_observer; race-in-progress indicator.
- ready  out  1  race request to race_official, registered.
- busy  out  1  high whenever FSM is not IDLE (combinational from state).
- race_count  out  COUNT_WIDTH  number of acknowledged races, wraps modulo 2^COUNT_WIDTH.
- timeout_err  out  1  one-cycle pulse on timeout abort, registered.

Behaviour:
- Reset (rst high at posedge):
  - next state IDLE; ready=0, timeout_err=0, race_count=0
  - delay counter and timeout counter = 0; lfsr=SEED (or 1)
  - Reset overrides everything, including mid-WAIT or mid-ASSERT.
- LFSR:
  - Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Shifts every non-reset cycle in every state; never reaches 0.
- Delay D = MIN_WAIT + (lfsr & WAIT_MASK), using the lfsr value before the current edge's shift. Delay counter width must hold MIN_WAIT+WAIT_MASK.
- FSM states IDLE, WAIT, ASSERT, COOLDOWN:
  - IDLE: if en && !start && !done -> cnt<=D, go WAIT; else hold.
  - WAIT:
    - cnt!=0 -> cnt<=cnt-1.
    - cnt==0 && !start && !done -> ready<=1, tcnt<=0, go ASSERT.
    - cnt==0 otherwise -> hold in WAIT with cnt==0.
    - en deassertion does not abort WAIT.
  - ASSERT:
    - start==1 -> ready<=0, race_count<=race_count+1, go COOLDOWN.
    - start==0 && tcnt==TIMEOUT-1 -> ready<=0, timeout_err<=1 for one cycle, go IDLE; race_count unchanged.
    - otherwise -> tcnt<=tcnt+1.
    - start wins when start arrives on the same edge as the timeout limit.
  - COOLDOWN: stay until start==0 && done==0 on the same edge, then go IDLE. No new launch from COOLDOWN directly.
- Latency:
  - Launch edge E0 (IDLE->WAIT) to ready high: exactly D+1 edges, assuming start/done stay low.
  - ready falls on the edge that samples start==1.
  - ready is never high in IDLE, WAIT or COOLDOWN.
- race_count 2^COUNT_WIDTH-1 + 1 wraps to 0 with no flag.
- timeout_err is 0 in every cycle except the single cycle after the abort edge.

Test Plan:
1. Reset then deterministic launch: MIN_WAIT=2, WAIT_MASK=0, en=1, start=done=0 -> ready rises 3 edges after the IDLE->WAIT edge; busy=1 from that edge.
2. Handshake completion: respond start=1 one cycle after ready, then done=1 for 5 cycles, then both 0 -> ready falls on the start edge; race_count 0->1; FSM leaves COOLDOWN only after start and done are both 0, then relaunches.
3. Timeout: TIMEOUT=4, start held 0 -> ready high exactly 4 cycles, then ready=0 and timeout_err=1 for exactly one cycle; race_count unchanged; FSM in IDLE.
4. Collision: start=1 on the same edge tcnt reaches TIMEOUT-1 -> race_count increments, timeout_err stays 0, FSM goes COOLDOWN.
5. Gating and interference:
   - en=0 keeps FSM in IDLE indefinitely.
   - done=1 while WAIT cnt==0 holds ready low until done drops; ready then rises on the next edge.
6. Reset mid-ASSERT and wrap:
   - rst=1 while ready=1 -> ready=0, race_count=0 the next cycle.
   - COUNT_WIDTH=2, 4 completed races -> race_count reads 0.
   - Random mode (WAIT_MASK=8'h0F): over 50 races every observed D lies in [2,17].
